// File: rtl/mult_seq_ctrl.sv
// Sequencer for a shift-add multiplier: walks LOAD, then WIDTH ADD/SHIFT pairs, then DONE.
// Optional `EARLY_TERM_EN: finish as soon as the datapath reports B==0 in ADD.
module mult_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             b_lsb,
  input  logic             b_zero,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             add_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             term_add;

`ifdef EARLY_TERM_EN
  assign term_add = b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign term_add      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = CNT_W'(WIDTH);
        state_d = S_ADD;
      end
      S_ADD:   state_d = term_add ? S_DONE : S_SHIFT;
      S_SHIFT: begin
        // Guarded decrement: the counter saturates at zero instead of wrapping.
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q <= CNT_W'(1)) ? S_DONE : S_ADD;
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign ld_a     = (state_q == S_LOAD);
  assign ld_b     = (state_q == S_LOAD);
  assign clr_p    = (state_q == S_LOAD);
  assign add_en   = (state_q == S_ADD) && b_lsb && !term_add;
  assign shift_en = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);
  assign cnt      = cnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: shift-add datapath model plus a scoreboard monitor checking each done.
module tb_mult_seq_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic b_lsb, b_zero;
  logic ld_a, ld_b, clr_p, add_en, shift_en, busy, done;
  logic [4:0] cnt;

  mult_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .b_lsb(b_lsb), .b_zero(b_zero),
    .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .add_en(add_en),
    .shift_en(shift_en), .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // datapath model
  logic [W-1:0]   a_in, b_in;
  logic [2*W-1:0] dA, dP;
  logic [W-1:0]   dB;
  assign b_lsb  = dB[0];
  assign b_zero = (dB == '0);
  always @(posedge clk) begin
    if (ld_a)     dA <= {{W{1'b0}}, a_in};
    if (ld_b)     dB <= b_in;
    if (clr_p)    dP <= '0;
    if (add_en)   dP <= dP + dA;
    if (shift_en) begin
      dA <= dA << 1;
      dB <= dB >> 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2*W-1:0] p;
    int             lat;
    int             sh;
    logic [W-1:0]   mask;
  } exp_t;
  exp_t sbq[$];

  // monitor
  int k_m, sh_m;
  logic [W-1:0] mask_m;
  logic after_load = 1'b0;
  logic prev_busy  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (after_load) begin
      chk("cnt_after_load", 64'(cnt), 64'(W));
      after_load = 1'b0;
    end
    if (ld_a === 1'b1) begin
      chk("no_start_while_busy", 64'(prev_busy), 64'(0));
      k_m = cyc; sh_m = 0; mask_m = '0; after_load = 1'b1;
    end
    if (shift_en === 1'b1) sh_m++;
    if (busy === 1'b1 && !ld_a && !shift_en && !done && sh_m < W)
      mask_m[sh_m[3:0]] = add_en;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("product",  64'(dP), 64'(e.p));
        chk("latency",  64'(cyc - k_m + 1), 64'(e.lat));
        chk("shifts",   64'(sh_m), 64'(e.sh));
        chk("add_mask", 64'(mask_m), 64'(e.mask));
      end
    end
    prev_busy = busy;
  end

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p, input int lat, input int sh,
                        input logic [W-1:0] mask);
    exp_t e;
    int t;
    e.p = p; e.lat = lat; e.sh = sh; e.mask = mask;
    sbq.push_back(e);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t);
    @(negedge clk);
  endtask

  initial begin
    int t, t1, t2, t3, nadd, nsh;
    logic seen_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",    64'(busy), 64'(0));
    chk("reset_strobes", 64'({ld_a, ld_b, clr_p, add_en, shift_en, done}), 64'(0));
    chk("reset_cnt",     64'(cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // abort together with start in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_start_idle", 64'(busy), 64'(0));
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

`ifdef EARLY_TERM_EN
    run_op(16'd3, 16'd5, 32'd15, 9, 3, 16'h0005);
    run_op(16'd7, 16'd2, 32'd14, 7, 2, 16'h0002);
    run_op(16'd9, 16'd0, 32'd0,  3, 0, 16'h0000);
`else
    run_op(16'd3, 16'd5, 32'd15, 34, 16, 16'h0005);
    run_op(16'd7, 16'd2, 32'd14, 34, 16, 16'h0002);
`endif
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 34, 16, 16'hFFFF);

    // reset during the SHIFT of iteration 7
    a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nsh = 0;
    for (int i = 0; i < 100 && nsh < 8; i++) begin
      @(negedge clk);
      if (shift_en) nsh++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy",    64'(busy), 64'(0));
    chk("rst_mid_strobes", 64'({ld_a, ld_b, clr_p, add_en, shift_en, done}), 64'(0));
    chk("rst_mid_cnt",     64'(cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // abort in the 5th ADD cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; nadd = 0;
    for (int i = 0; i < 100 && nadd < 5; i++) begin
      @(negedge clk);
      if (busy && !ld_a && !shift_en && !done) nadd++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_cnt",  64'(cnt), 64'(0));
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'(0));
    run_op(16'd1234, 16'd3, 32'd3702, 34, 16, 16'h0003);

    // start held high: back-to-back operations
    for (int i = 0; i < 3; i++) sbq.push_back('{32'hFFFE0001, 34, 16, 16'hFFFF});
    a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
    wait_done(t1);
    wait_done(t2);
    wait_done(t3);
    start = 1'b0;
    chk("b2b_gap1", 64'(t2 - t1), 64'(35));
    chk("b2b_gap2", 64'(t3 - t2), 64'(35));
    repeat (3) @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'(0));

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
